// File: rtl/tl_lsi_pkg.sv
// Shared constants and types for the TL-UL to LSI bridge.
// Holds the TL opcodes, the LSI opc/bmsk encodings and the bridge FSM states.
package tl_lsi_pkg;

  localparam logic [2:0] PUT_FULL        = 3'd0;
  localparam logic [2:0] PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] GET             = 3'd4;
  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  localparam logic [2:0] LSI_RD = 3'b000;
  localparam logic [2:0] LSI_WR = 3'b001;

  localparam logic [1:0] BMSK_WORD = 2'b00;
  localparam logic [1:0] BMSK_HALF = 2'b01;
  localparam logic [1:0] BMSK_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic logic [1:0] size2bmsk(input logic [1:0] sz);
    unique case (sz)
      2'd0:    size2bmsk = BMSK_BYTE;
      2'd1:    size2bmsk = BMSK_HALF;
      default: size2bmsk = BMSK_WORD;
    endcase
  endfunction

endpackage

// File: rtl/tl_lsi_bridge.sv
// TL-UL slave to LSI register-bus master, one transaction in flight.
// Optional LSI_TIMEOUT_EN: denies a request whose LSI response never arrives.
module tl_lsi_bridge
  import tl_lsi_pkg::*;
#(
  parameter int SOURCE_W       = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [1:0]          a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic [31:0]         a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_size,
  output logic [SOURCE_W-1:0] d_source,
  output logic                d_denied,
  output logic [31:0]         d_data,
  output logic                lsi_vld_o,
  output logic [1:0]          lsi_sbsp_o,
  output logic [31:0]         lsi_data_o,
  output logic [2:0]          lsi_opc_o,
  output logic [1:0]          lsi_bmsk_o,
  input  logic                lsi_busy_i,
  input  logic [1:0]          lsi_err_i,
  input  logic [31:0]         lsi_data_i,
  input  logic                lsi_rvld_i,
  output logic                lsi_rsp_busy_o
);

  state_t state, state_nx;

  logic [2:0]          op_q;
  logic [1:0]          size_q;
  logic [SOURCE_W-1:0] src_q;
  logic [1:0]          sbsp_q;
  logic [31:0]         wdata_q;
  logic [2:0]          opc_q;
  logic [1:0]          bmsk_q;
  logic                denied_q;
  logic [31:0]         rdata_q;
  logic                req_bad;
  logic                to_hit;
  logic                accept;
  logic                rsp_take;

  assign req_bad = !(a_opcode == PUT_FULL ||
                     a_opcode == PUT_PARTIAL ||
                     a_opcode == GET) ||
                   (a_size == 2'd3);

  assign accept   = (state == IDLE) && a_valid;
  assign rsp_take = (state == WAIT) && lsi_rvld_i;

  // Only [3:2] of the address reaches the LSI bus; lanes come from a_size.
  logic unused_ok;
  assign unused_ok = ^{a_address[31:4], a_address[1:0], a_mask};

`ifdef LSI_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state != WAIT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign to_hit = (state == WAIT) && !lsi_rvld_i &&
                  (cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYCLES;
  assign to_hit    = 1'b0;
`endif

  always_comb begin
    state_nx  = state;
    a_ready   = 1'b0;
    lsi_vld_o = 1'b0;
    d_valid   = 1'b0;
    unique case (state)
      IDLE: begin
        a_ready = !reset;
        if (a_valid) state_nx = req_bad ? RESP : ISSUE;
      end
      ISSUE: begin
        if (!lsi_busy_i) begin
          lsi_vld_o = 1'b1;
          state_nx  = WAIT;
        end
      end
      WAIT: begin
        if (lsi_rvld_i || to_hit) state_nx = RESP;
      end
      RESP: begin
        d_valid = 1'b1;
        if (d_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      size_q   <= '0;
      src_q    <= '0;
      sbsp_q   <= '0;
      wdata_q  <= '0;
      opc_q    <= '0;
      bmsk_q   <= '0;
      denied_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q     <= a_opcode;
        size_q   <= a_size;
        src_q    <= a_source;
        sbsp_q   <= a_address[3:2];
        wdata_q  <= a_data;
        opc_q    <= (a_opcode == GET) ? LSI_RD : LSI_WR;
        bmsk_q   <= size2bmsk(a_size);
        denied_q <= req_bad;
        rdata_q  <= '0;
      end
      // Read data only survives a clean Get; errors leave d_data at zero.
      if (rsp_take) begin
        denied_q <= (lsi_err_i != 2'b00);
        if (op_q == GET && lsi_err_i == 2'b00) rdata_q <= lsi_data_i;
      end else if (to_hit) begin
        denied_q <= 1'b1;
      end
    end
  end

  assign d_opcode       = (op_q == GET) ? ACCESS_ACK_DATA : ACCESS_ACK;
  assign d_size         = size_q;
  assign d_source       = src_q;
  assign d_denied       = denied_q;
  assign d_data         = rdata_q;
  assign lsi_sbsp_o     = sbsp_q;
  assign lsi_data_o     = wdata_q;
  assign lsi_opc_o      = opc_q;
  assign lsi_bmsk_o     = bmsk_q;
  assign lsi_rsp_busy_o = (state != WAIT);

endmodule

// File: tb/tb_tl_lsi_bridge.sv
// Directed self-checking bench for tl_lsi_bridge.
// Build with +define+LSI_TIMEOUT_EN to also cover the response timeout.
module tb_tl_lsi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [1:0]  a_size;
  logic [3:0]  a_source;
  logic [31:0] a_address;
  logic [3:0]  a_mask;
  logic [31:0] a_data;
  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_size;
  logic [3:0]  d_source;
  logic        d_denied;
  logic [31:0] d_data;
  logic        lsi_vld_o;
  logic [1:0]  lsi_sbsp_o;
  logic [31:0] lsi_data_o;
  logic [2:0]  lsi_opc_o;
  logic [1:0]  lsi_bmsk_o;
  logic        lsi_busy_i;
  logic [1:0]  lsi_err_i;
  logic [31:0] lsi_data_i;
  logic        lsi_rvld_i;
  logic        lsi_rsp_busy_o;

  int checks   = 0;
  int failures = 0;

  int lat, pulses, vld_at, wait_n;
  logic [1:0]  cap_sbsp;
  logic [2:0]  cap_opc;
  logic [1:0]  cap_bmsk;
  logic [31:0] cap_data;

  always #5 clk = ~clk;

  tl_lsi_bridge #(.SOURCE_W(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode),
    .a_size(a_size), .a_source(a_source), .a_address(a_address),
    .a_mask(a_mask), .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode),
    .d_size(d_size), .d_source(d_source), .d_denied(d_denied),
    .d_data(d_data),
    .lsi_vld_o(lsi_vld_o), .lsi_sbsp_o(lsi_sbsp_o),
    .lsi_data_o(lsi_data_o), .lsi_opc_o(lsi_opc_o),
    .lsi_bmsk_o(lsi_bmsk_o), .lsi_busy_i(lsi_busy_i),
    .lsi_err_i(lsi_err_i), .lsi_data_i(lsi_data_i),
    .lsi_rvld_i(lsi_rvld_i), .lsi_rsp_busy_o(lsi_rsp_busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Plays both TL master and LSI peripheral up to the first d_valid.
  task automatic txn(input logic [2:0] op, input logic [1:0] sz,
                     input logic [3:0] src, input logic [31:0] addr,
                     input logic [31:0] wd, input int busy_n,
                     input bit respond, input logic [1:0] err,
                     input logic [31:0] rd);
    bit pend;
    int i;
    a_valid   = 1'b1;
    a_opcode  = op;
    a_size    = sz;
    a_source  = src;
    a_address = addr;
    a_data    = wd;
    a_mask    = 4'hf;
    #1;
    chk("a_ready_idle", {31'd0, a_ready}, 32'd1);
    tick();
    a_valid = 1'b0;
    lat = 1; pulses = 0; vld_at = -1; wait_n = 0;
    pend = 1'b0; i = 0;
    while (!d_valid && lat < 64) begin
      lsi_rvld_i = 1'b0;
      if (pend && respond) begin
        lsi_rvld_i = 1'b1;
        lsi_err_i  = err;
        lsi_data_i = rd;
        pend       = 1'b0;
      end
      lsi_busy_i = (i < busy_n);
      #1;
      if (!lsi_rsp_busy_o) wait_n++;
      if (lsi_vld_o) begin
        pulses++;
        vld_at   = lat;
        cap_sbsp = lsi_sbsp_o;
        cap_opc  = lsi_opc_o;
        cap_bmsk = lsi_bmsk_o;
        cap_data = lsi_data_o;
        pend     = 1'b1;
      end
      tick();
      lat++;
      i++;
    end
    lsi_rvld_i = 1'b0;
    lsi_busy_i = 1'b0;
  endtask

  // Holds d_ready low, requiring frozen D outputs and a_ready low, then acks.
  task automatic finish_d(input int hold);
    logic [40:0] snap;
    bit ok;
    ok   = 1'b1;
    snap = {d_opcode, d_size, d_source, d_denied, d_data};
    for (int k = 0; k < hold; k++) begin
      tick();
      if ({d_opcode, d_size, d_source, d_denied, d_data} != snap) ok = 1'b0;
      if (!d_valid || a_ready) ok = 1'b0;
    end
    chk("d_hold_stable", {31'd0, ok}, 32'd1);
    d_ready = 1'b1;
    tick();
    d_ready = 1'b0;
    chk("a_ready_after_d", {30'd0, d_valid, a_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 0; a_opcode = 0; a_size = 0; a_source = 0;
    a_address = 0; a_mask = 0; a_data = 0; d_ready = 0;
    lsi_busy_i = 0; lsi_err_i = 0; lsi_data_i = 0; lsi_rvld_i = 0;
    tick();
    tick();
    chk("rst_a_ready", {31'd0, a_ready}, 32'd0);
    chk("rst_d_valid", {31'd0, d_valid}, 32'd0);
    chk("rst_lsi_vld", {31'd0, lsi_vld_o}, 32'd0);
    chk("rst_rsp_busy", {31'd0, lsi_rsp_busy_o}, 32'd1);
    chk("rst_lsi_out",
        {23'd0, lsi_sbsp_o, lsi_opc_o, lsi_bmsk_o, d_denied, 1'b0},
        32'd0);
    chk("rst_d_data", d_data, 32'd0);
    chk("rst_lsi_data", lsi_data_o, 32'd0);
    reset = 1'b0;
    #1;
    chk("idle_a_ready", {31'd0, a_ready}, 32'd1);

    // Get 0x08, zero-wait peripheral
    txn(3'd4, 2'd2, 4'd3, 32'h8, 32'h0, 0, 1'b1, 2'b00, 32'h41);
    chk("get_latency", lat, 32'd3);
    chk("get_pulses", pulses, 32'd1);
    chk("get_lsi", {24'd0, cap_sbsp, cap_opc, cap_bmsk}, {24'd0, 2'b10, 3'b000, 2'b00});
    chk("get_wait_cycles", wait_n, 32'd1);
    chk("get_d_fields", {20'd0, d_opcode, d_size, d_source, d_denied},
        {20'd0, 3'd1, 2'd2, 4'd3, 1'b0});
    chk("get_d_data", d_data, 32'h41);
    finish_d(0);

    // Stray response while idle must be ignored
    lsi_rvld_i = 1'b1; lsi_data_i = 32'hBAD; lsi_err_i = 2'b11;
    tick();
    lsi_rvld_i = 1'b0;
    tick();
    chk("stray_rvld", {30'd0, d_valid, a_ready}, 32'd1);

    // PutFullData 0x04; peripheral read data must not leak into d_data
    txn(3'd0, 2'd2, 4'd5, 32'h4, 32'h6C87, 0, 1'b1, 2'b00, 32'hDEADBEEF);
    chk("put_latency", lat, 32'd3);
    chk("put_pulses", pulses, 32'd1);
    chk("put_lsi", {24'd0, cap_sbsp, cap_opc, cap_bmsk}, {24'd0, 2'b01, 3'b001, 2'b00});
    chk("put_lsi_data", cap_data, 32'h6C87);
    chk("put_d_fields", {20'd0, d_opcode, d_size, d_source, d_denied},
        {20'd0, 3'd0, 2'd2, 4'd5, 1'b0});
    chk("put_d_data", d_data, 32'h0);
    finish_d(0);

    // PutPartial halfword with busy held 5 cycles in ISSUE
    txn(3'd1, 2'd1, 4'd1, 32'h0, 32'h1234, 5, 1'b1, 2'b00, 32'h0);
    chk("busy_pulses", pulses, 32'd1);
    chk("busy_vld_at", vld_at, 32'd6);
    chk("busy_latency", lat, 32'd8);
    chk("busy_lsi", {24'd0, cap_sbsp, cap_opc, cap_bmsk}, {24'd0, 2'b00, 3'b001, 2'b01});
    finish_d(0);

    // Byte Get, peripheral error 01, d_ready held low 4 cycles
    txn(3'd4, 2'd0, 4'd9, 32'hC, 32'h0, 0, 1'b1, 2'b01, 32'h55);
    chk("err_lsi", {24'd0, cap_sbsp, cap_opc, cap_bmsk}, {24'd0, 2'b11, 3'b000, 2'b10});
    chk("err_d_fields", {20'd0, d_opcode, d_size, d_source, d_denied},
        {20'd0, 3'd1, 2'd0, 4'd9, 1'b1});
    chk("err_d_data", d_data, 32'h0);
    finish_d(4);

    // Arithmetic opcode: denied, no LSI traffic
    txn(3'd2, 2'd2, 4'd2, 32'h4, 32'h0, 0, 1'b1, 2'b00, 32'h0);
    chk("arith_pulses", pulses, 32'd0);
    chk("arith_latency", lat, 32'd1);
    chk("arith_denied", {31'd0, d_denied}, 32'd1);
    finish_d(1);

    // Size 3 Get: denied, no LSI traffic
    txn(3'd4, 2'd3, 4'd7, 32'h8, 32'h0, 0, 1'b1, 2'b00, 32'h77);
    chk("size3_pulses", pulses, 32'd0);
    chk("size3_d", {30'd0, d_denied, d_opcode[0]}, 32'd3);
    chk("size3_d_data", d_data, 32'h0);
    finish_d(0);

`ifdef LSI_TIMEOUT_EN
    // No response: forced deny after exactly 16 WAIT cycles
    txn(3'd4, 2'd2, 4'd4, 32'h8, 32'h0, 0, 1'b0, 2'b00, 32'h0);
    chk("to_wait_cycles", wait_n, 32'd16);
    chk("to_latency", lat, 32'd18);
    chk("to_d", {30'd0, d_denied, d_opcode[0]}, 32'd3);
    chk("to_d_data", d_data, 32'h0);
    finish_d(0);
`endif

    // Reset in WAIT drops the transaction
    a_valid = 1'b1; a_opcode = 3'd4; a_size = 2'd2;
    a_source = 4'd6; a_address = 32'h8;
    tick();
    a_valid = 1'b0;
    tick();
    chk("rstw_in_wait", {31'd0, lsi_rsp_busy_o}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rstw_a_ready", {30'd0, a_ready, lsi_rsp_busy_o}, 32'd1);
    tick();
    reset = 1'b0;
    lsi_rvld_i = 1'b1; lsi_data_i = 32'h99;
    tick();
    lsi_rvld_i = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
        if (d_valid) seen = 1'b1;
        tick();
      end
      chk("rstw_no_d", {31'd0, seen}, 32'd0);
    end
    chk("rstw_idle", {31'd0, a_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tl_lsi_bridge.md
Name: tl_lsi_bridge

Overview:
TileLink-UL slave to LSI register-bus master converter. It sits directly upstream of polaris_uart and any other LSI peripheral, driving their vld/sbsp/data/opc/bmsk request inputs and consuming their vld/error/data responses. It turns one TL-UL Get/PutFullData/PutPartialData into one LSI transaction and returns a TL-UL AccessAck/AccessAckData. Only one transaction is outstanding at a time.

Parameters:
SOURCE_W, 4, width of a_source/d_source
TIMEOUT_CYCLES, 1024, cycles without an LSI response before a forced error (used only with the optional feature)

Ports:
clk  in  1  bridge clock
reset  in  1  asynchronous, active-high reset
a_valid  in  1  TL A-channel valid
a_ready  out  1  TL A-channel ready
a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get
a_size  in  2  log2 bytes (0..2)
a_source  in  SOURCE_W  requester id
a_address  in  32  byte address; [3:2] selects the LSI register
a_mask  in  4  byte lanes
a_data  in  32  write data
d_valid  out  1  TL D-channel valid
d_ready  in  1  TL D-channel ready
d_opcode  out  3  0=AccessAck, 1=AccessAckData
d_size  out  2  echo of a_size
d_source  out  SOURCE_W  echo of a_source
d_denied  out  1  error response
d_data  out  32  read data
lsi_vld_o  out  1  one-cycle request strobe
lsi_sbsp_o  out  2  register select = a_address[3:2]
lsi_data_o  out  32  write data
lsi_opc_o  out  3  000 read, 001 write
lsi_bmsk_o  out  2  00 word, 01 halfword, 10 byte (from a_size)
lsi_busy_i  in  1  peripheral cannot accept a request
lsi_err_i  in  2  response error code; 00 = OK
lsi_data_i  in  32  read data
lsi_rvld_i  in  1  response valid, one cycle
lsi_rsp_busy_o  out  1  bridge cannot take a response (peripheral must hold it)

Behaviour:
- Reset (async, active-high): state IDLE. a_ready=0 while reset is high. d_valid=0, lsi_vld_o=0, d_denied=0, d_data=0, lsi_* outputs=0, lsi_rsp_busy_o=1.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE: a_ready=1. On a_valid&a_ready, latch opcode, size, source, address[3:2], data and mask.
  - Unsupported opcode, or a_size=3: go directly to RESP with d_denied=1. No LSI traffic.
  - Otherwise go to ISSUE.
- ISSUE: while lsi_busy_i=1, hold and keep lsi_vld_o=0. On the first cycle with lsi_busy_i=0, pulse lsi_vld_o for exactly one cycle with sbsp/data/opc/bmsk stable, then go to WAIT. lsi_opc_o=001 for Put*, 000 for Get.
- WAIT: lsi_rsp_busy_o=0 (in all other states it is 1). On lsi_rvld_i:
  - capture lsi_data_i into d_data for Get;
  - d_denied = (lsi_err_i != 00);
  - go to RESP.
- RESP: d_valid=1. d_opcode = 1 for Get, 0 otherwise. d_size and d_source echo the request. Outputs are stable until d_ready. On d_valid&d_ready, go to IDLE.
- Back-to-back: a_ready reasserts the cycle after the D handshake.
- Minimum latency from A handshake to d_valid is 3 cycles (zero-wait peripheral responding the cycle after lsi_vld_o).
- An lsi_rvld_i outside WAIT is ignored.
- d_data is 0 for write responses and for denied responses.
- Reset mid-transaction drops it silently; no D response follows.

Optional Feature:
LSI_TIMEOUT_EN
- Defined: a counter clears on entry to WAIT and increments each WAIT cycle. On reaching TIMEOUT_CYCLES-1 without lsi_rvld_i, go to RESP with d_denied=1 and d_data=0.
- Undefined: no counter; WAIT lasts until lsi_rvld_i.

Decomposition:
- Package tl_lsi_pkg: TL opcode constants (PUT_FULL, PUT_PARTIAL, GET, ACCESS_ACK, ACCESS_ACK_DATA), LSI opc constants (LSI_RD, LSI_WR), bmsk encodings, FSM state enum.
- No sub-module; the timeout counter stays inline.

Test Plan:
- Get, address 0x08, size 2, source 3; peripheral returns 0x0000_0041 with err 00 one cycle after lsi_vld_o -> lsi_sbsp_o=10, lsi_opc_o=000; d_opcode=1, d_data=0x41, d_source=3, d_denied=0; d_valid 3 cycles after the A handshake.
- PutFullData, address 0x04, data 0x6C87 -> single lsi_vld_o pulse with sbsp=01, opc=001, data 0x6C87; AccessAck d_opcode=0, d_denied=0.
- lsi_busy_i held high 5 cycles during ISSUE -> no lsi_vld_o until busy drops, then exactly one pulse.
- Peripheral returns err 01 -> d_denied=1; d_ready held low 4 cycles -> D outputs stable and a_ready=0 throughout.
- a_opcode=2 (Arithmetic) -> d_denied=1, no lsi_vld_o.
- With LSI_TIMEOUT_EN and TIMEOUT_CYCLES=16, no response -> d_denied=1 exactly 16 WAIT cycles later. Reset asserted during WAIT -> IDLE, no D response.
